muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; result width is 2*WIDTH.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request; an operation is accepted on a rising edge where start=1 and state is IDLE or DONE.
REQ-005 check  input  2  operation select; check[0]=0 multiply, check[0]=1 divide; check[1] is ignored.
REQ-006 in_A  input  WIDTH  multiplicand or dividend, unsigned.
REQ-007 in_B  input  WIDTH  multiplier or divisor, unsigned.
REQ-008 busy  output  1  high while an operation is iterating (state RUN).
REQ-009 done  output  1  single-cycle pulse; out is valid when it is high.
REQ-010 out  output  2*WIDTH  registered result; multiply gives the full product; divide gives {quotient, remainder} (quotient in upper WIDTH bits).

Function
REQ-011 States SHALL be IDLE, RUN and DONE, with one-hot or binary encoding at implementer's choice.
- IDLE -> RUN on accepted start.
- RUN -> DONE after the WIDTH-th iteration.
- DONE -> RUN on accepted start; otherwise DONE -> IDLE.
REQ-012 On accept, in_A, in_B and check[0] SHALL be latched; input changes after the accept edge SHALL NOT affect the result.
REQ-013 Each RUN cycle SHALL perform exactly one iteration; an iteration counter of ceil(log2(WIDTH)) bits counts 0..WIDTH-1.
- The counter reaching WIDTH-1 ends RUN.
- The counter SHALL NOT wrap into a further iteration.
REQ-014 Multiply SHALL use radix-2 shift-add, unsigned, 2*WIDTH-bit accumulator; no truncation.
REQ-015 Divide SHALL use restoring (or non-restoring with final correction) unsigned division; remainder < divisor always.
REQ-016 Divide by zero SHALL NOT use X or special-case the timing: quotient = all ones, remainder = latched in_A, same latency.
REQ-017 Latency: accept edge at cycle 0; busy=1 in cycles 1..WIDTH; done=1 and out valid in cycle WIDTH+1 (cycle 33 for WIDTH=32).
REQ-018 busy and done SHALL never be high together.
REQ-019 out SHALL update only on the edge entering DONE, and SHALL hold its value through IDLE and through the next RUN until that operation completes.
REQ-020 start while in RUN SHALL be ignored: no queueing, no restart, no error flag.
REQ-021 start high in DONE SHALL be accepted: the next cycle is RUN with busy=1 and done=0, giving back-to-back throughput of one result per WIDTH+1 cycles.
REQ-022 start held high continuously SHALL restart an operation on every DONE cycle.

Reset
REQ-023 With rst=1 at a rising edge: state=IDLE, busy=0, done=0, out=0, counter=0, internal operand registers=0.
REQ-024 rst SHALL take priority over start and over any state; asserting it mid-RUN SHALL abort the operation with no done pulse.
REQ-025 The first edge with rst=0 and start=1 SHALL be accepted normally.

Verification
REQ-026 Multiply 0xFFFFFFFF x 0xFFFFFFFF, check=2'b00 -> out=64'hFFFFFFFE_00000001, done exactly 33 cycles after the accept edge, busy high for 32 cycles.
REQ-027 Divide 100 / 7, check=2'b01 -> out={32'd14, 32'd2}; also check=2'b11 with 0xFFFFFFFF / 0x10 -> {32'h0FFFFFFF, 32'hF}.
REQ-028 Divide 5 / 0 -> out={32'hFFFFFFFF, 32'd5} at cycle 33, with no X on out.
REQ-029 Start 6 x 7, then change in_A/in_B and pulse start during RUN -> single result 64'd42, only one done pulse, busy not extended.
REQ-030 Assert rst at cycle 10 of a multiply -> next cycle busy=0, done=0, out=0; a following 3 x 4 yields 64'd12 at cycle 33 with no stale done.
REQ-031 Start held high across two operations (12/5, then 9x9) -> done pulses 33 cycles apart carrying {2,2} then 81; out holds {2,2} throughout the second RUN.

Source files
------------

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// muldiv_seq : iterative unsigned multiply (shift-add) / divide (restoring)
// Revision   : 1.0
// ============================================================================
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         check,
  input  logic [WIDTH-1:0]   in_A,
  input  logic [WIDTH-1:0]   in_B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] step;

  // check[1] has no function; the name keeps it out of unused-signal reports
  logic unused_check_hi;
  assign unused_check_hi = check[1];

  // One iteration. acc holds {partial product, multiplier} for multiply and
  // {partial remainder, dividend/quotient bits} for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_part = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_part >= {1'b0, opnd_q});
    div_diff = div_part[WIDTH-1:0] - opnd_q;
    if (div_q) begin
      step = {(div_ge ? div_diff : div_part[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    out_d   = out_q;
    accept  = start && (state_q != RUN);
    case (state_q)
      RUN: begin
        acc_d = step;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          out_d   = div_q ? {step[WIDTH-1:0], step[2*WIDTH-1:WIDTH]} : step;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = check[0];
          opnd_d  = check[0] ? in_B : in_A;
          acc_d   = {{WIDTH{1'b0}}, (check[0] ? in_A : in_B)};
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule
`default_nettype wire
